// File: rtl/pw_trigger_sequencer.sv
// Multi-pulse trigger generator: per-pulse delay and width, clamped pulse count, global enable.
// All outputs are registered; a match while busy is counted as ignored, never retriggered.
module pw_trigger_sequencer #(
    parameter int unsigned pNUM_TRIGGER_PULSES = 8,
    parameter int unsigned pNUM_TRIGGER_WIDTH  = 4,
    parameter int unsigned pCNT_WIDTH          = 24
) (
    input  logic                                        trigger_clk,
    input  logic                                        reset_n,
    input  logic                                        I_match,
    input  logic                                        I_trigger_enable,
    input  logic [pNUM_TRIGGER_WIDTH-1:0]               I_num_triggers,
    input  logic [pCNT_WIDTH*pNUM_TRIGGER_PULSES-1:0]   I_trigger_delay,
    input  logic [pCNT_WIDTH*pNUM_TRIGGER_PULSES-1:0]   I_trigger_width,
    input  logic                                        I_clear_ignored,
    output logic                                        O_trigger,
    output logic                                        O_busy,
    output logic [pNUM_TRIGGER_WIDTH-1:0]               O_pulse_index,
    output logic                                        O_done,
    output logic [7:0]                                  O_ignored_count
);

    typedef enum logic [1:0] {StIdle, StDelay, StPulse} state_e;

    localparam logic [pNUM_TRIGGER_WIDTH-1:0] MaxPulses = pNUM_TRIGGER_WIDTH'(pNUM_TRIGGER_PULSES);
    localparam logic [pNUM_TRIGGER_WIDTH-1:0] IdxOne    = pNUM_TRIGGER_WIDTH'(1);
    localparam logic [pCNT_WIDTH-1:0]         CntOne    = pCNT_WIDTH'(1);

    state_e                          state_q, state_d;
    logic [pCNT_WIDTH-1:0]           cnt_q, cnt_d;
    logic [pNUM_TRIGGER_WIDTH-1:0]   idx_q, idx_d;
    logic [pNUM_TRIGGER_WIDTH-1:0]   num_q, num_d;
    logic                            trigger_q, trigger_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic [7:0]                      ign_q, ign_d;

    logic [pNUM_TRIGGER_WIDTH-1:0]   dly_sel;
    logic [pCNT_WIDTH-1:0]           dly_raw, wid_raw, g_eff, w_eff;

    // Delay/width are read only at the moment their counter loads.
    always_comb begin
        dly_sel = (state_q == StIdle) ? '0 : idx_q + IdxOne;
        dly_raw = '0;
        wid_raw = '0;
        for (int i = 0; i < int'(pNUM_TRIGGER_PULSES); i++) begin
            if (dly_sel == pNUM_TRIGGER_WIDTH'(i)) begin
                dly_raw = I_trigger_delay[i*pCNT_WIDTH +: pCNT_WIDTH];
            end
            if (idx_q == pNUM_TRIGGER_WIDTH'(i)) begin
                wid_raw = I_trigger_width[i*pCNT_WIDTH +: pCNT_WIDTH];
            end
        end
        g_eff = (dly_raw == '0) ? CntOne : dly_raw;
        w_eff = (wid_raw == '0) ? CntOne : wid_raw;
    end

    always_ff @(posedge trigger_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            num_q     <= '0;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ign_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            num_q     <= num_d;
            trigger_q <= trigger_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ign_q     <= ign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        num_d   = num_q;
        case (state_q)
            StIdle: begin
                if (I_match && I_trigger_enable) begin
                    if (I_num_triggers == '0) begin
                        num_d = IdxOne;
                    end else if (I_num_triggers > MaxPulses) begin
                        num_d = MaxPulses;
                    end else begin
                        num_d = I_num_triggers;
                    end
                    idx_d = '0;
                    if (dly_raw == '0) begin
                        state_d = StPulse;
                        cnt_d   = w_eff;
                    end else begin
                        state_d = StDelay;
                        cnt_d   = dly_raw;
                    end
                end
            end
            StDelay: begin
                if (!I_trigger_enable) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == CntOne) begin
                    state_d = StPulse;
                    cnt_d   = w_eff;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StPulse: begin
                if (!I_trigger_enable) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == CntOne) begin
                    // num_q >= 1, so the subtraction cannot wrap.
                    if (idx_q < num_q - IdxOne) begin
                        state_d = StDelay;
                        idx_d   = idx_q + IdxOne;
                        cnt_d   = g_eff;
                    end else begin
                        state_d = StIdle;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        trigger_d = (state_d == StPulse);
        busy_d    = (state_d != StIdle);
        done_d    = (state_q == StPulse) && (state_d == StIdle) && I_trigger_enable;
        ign_d     = ign_q;
        if (I_clear_ignored) begin
            ign_d = '0;
        end else if (I_match && (state_q != StIdle) && (ign_q != 8'hFF)) begin
            ign_d = ign_q + 8'd1;
        end
    end

    assign O_trigger       = trigger_q;
    assign O_busy          = busy_q;
    assign O_pulse_index   = idx_q;
    assign O_done          = done_q;
    assign O_ignored_count = ign_q;

endmodule
